// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared types, default timing and counter sizing for the key front-end
package input_pkg;

  // Per-key debounce state; level is 1 in HELD and RELEASE_PEND
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  // Board defaults, assuming a 50 MHz system clock
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  // Width large enough to hold the largest of the three cycle counts
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - one key channel: synchroniser, debounce FSM and auto-repeat
module button_debouncer
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic press_nxt,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_T    = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_T    = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_first_q, rpt_first_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  logic          p;
  logic [CW-1:0] rpt_inc;
  logic [CW-1:0] rpt_target;

  // Next-state logic: synchroniser shift, debounce FSM and repeat scheduling
  always_comb begin
    sync1_d     = key_n;
    sync2_d     = sync1_q;
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    p           = ~sync2_q;
    rpt_inc     = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + ONE;
    rpt_target  = rpt_first_q ? RD_T : RP_T;

    case (state_q)
      IDLE: begin
        if (p) begin
          state_d  = PRESS_PEND;
          db_cnt_d = '0;
        end
      end
      PRESS_PEND: begin
        if (!p) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = HELD;
          db_cnt_d    = '0;
          press_d     = 1'b1;
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + ONE;
        end
      end
      HELD: begin
        if (!p) begin
          state_d  = RELEASE_PEND;
          db_cnt_d = '0;
        end
      end
      RELEASE_PEND: begin
        if (p) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          db_cnt_d  = '0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase

    // Repeat timing runs while the key is logically down; the release cycle itself never repeats
    if (((state_q == HELD) || (state_q == RELEASE_PEND)) && (state_d != IDLE)) begin
      if (rpt_inc == rpt_target) begin
        repeat_d    = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_inc;
      end
    end

    level_d = (state_d == HELD) || (state_d == RELEASE_PEND);
  end

  // State register; the synchroniser resets to the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign press_nxt     = press_d & ~rst;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - key debouncing for all channels plus column cursor and drop gating
module button_conditioner
  import input_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned NUM_COLS        = 7,
  parameter int unsigned WRAP            = 1,
  parameter int unsigned LEFT_IDX        = 0,
  parameter int unsigned RIGHT_IDX       = 1,
  parameter int unsigned DROP_IDX        = 2,
  localparam int unsigned COL_W          = $clog2(NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_n,
  input  logic [COL_W-1:0]    switches,
  input  logic                cursor_mode,
  input  logic                lock,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat,
  output logic [COL_W-1:0]    column_select,
  output logic                drop_en
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

  logic [NUM_BTNS-1:0] level_w;
  logic [NUM_BTNS-1:0] press_w;
  logic [NUM_BTNS-1:0] press_nxt_w;
  logic [NUM_BTNS-1:0] release_w;
  logic [NUM_BTNS-1:0] repeat_w;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_deb (
      .clk           (clk),
      .rst           (rst),
      .key_n         (btn_n[i]),
      .level         (level_w[i]),
      .press         (press_w[i]),
      .press_nxt     (press_nxt_w[i]),
      .release_pulse (release_w[i]),
      .repeat_pulse  (repeat_w[i])
    );
  end

  assign btn_level   = level_w;
  assign btn_press   = press_w;
  assign btn_release = release_w;
  assign btn_repeat  = repeat_w;

  logic [COL_W-1:0] col_q, col_d;
  logic             drop_q, drop_d;
  logic             left_ev;
  logic             right_ev;

  // Cursor: follow clamped switches in mode 0, step on key events in mode 1
  always_comb begin
    col_d    = col_q;
    left_ev  = press_w[LEFT_IDX] | repeat_w[LEFT_IDX];
    right_ev = press_w[RIGHT_IDX] | repeat_w[RIGHT_IDX];
    // drop is registered alongside the press flop so both pulse in the same cycle
    drop_d   = press_nxt_w[DROP_IDX] & ~lock;

    if (!cursor_mode) begin
      col_d = (switches > COL_LAST) ? COL_LAST : switches;
    end else if (!lock && (left_ev ^ right_ev)) begin
      if (left_ev) begin
        if (col_q == '0) col_d = (WRAP != 0) ? COL_LAST : '0;
        else             col_d = col_q - COL_ONE;
      end else begin
        if (col_q >= COL_LAST) col_d = (WRAP != 0) ? '0 : COL_LAST;
        else                   col_d = col_q + COL_ONE;
      end
    end
  end

  // Cursor and drop registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      drop_q <= drop_d;
    end
  end

  assign column_select = col_q;
  assign drop_en       = drop_q;

endmodule
